// File: rtl/mem_access_seq_if.sv
// Request/strobe bundle between the main control FSM and the memory-access sequencer.
// The master modport belongs to the requester; the slave modport belongs to the sequencer.
interface mem_access_seq_if;
  logic       fetch_req;
  logic       data_req;
  logic       data_we;
  logic       exc_req;
  logic [1:0] exc_code;
  logic [2:0] iord;
  logic       mem_wr;
  logic       ir_wr;
  logic       mdr_wr;
  logic       epc_wr;
  logic       pc_vec_wr;
  logic       busy;
  logic       done;

  modport master (
    output fetch_req, data_req, data_we, exc_req, exc_code,
    input  iord, mem_wr, ir_wr, mdr_wr, epc_wr, pc_vec_wr, busy, done
  );

  modport slave (
    input  fetch_req, data_req, data_we, exc_req, exc_code,
    output iord, mem_wr, ir_wr, mdr_wr, epc_wr, pc_vec_wr, busy, done
  );
endinterface

// File: rtl/mem_access_seq.sv
// Multicycle memory-access sequencer: arbitrates fetch, load/store and exception-vector
// reads, drives the address-mux select and the matching datapath write strobes.
module mem_access_seq #(
  parameter int MEM_LAT = 2
) (
  input logic             clk,
  input logic             reset,
  mem_access_seq_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    STORE,
    EXC_EPC,
    EXC_RD
  } state_t;

  localparam logic [2:0] LAT = 3'(MEM_LAT);

  state_t     r_state;
  state_t     w_next;
  logic [2:0] r_cnt;
  logic       r_pend_valid;
  logic [1:0] r_pend_code;

  logic       w_exc_in;
  logic       w_last;
  logic       w_pend_clr;
  logic       w_counting;
  logic [2:0] w_vec;

  logic [2:0] w_iord;
  logic       w_mem_wr;
  logic       w_ir_wr;
  logic       w_mdr_wr;
  logic       w_epc_wr;
  logic       w_pc_vec_wr;
  logic       w_busy;
  logic       w_done;

  assign w_exc_in   = bus.exc_req && (bus.exc_code != 2'b00);
  assign w_last     = (r_cnt == LAT);
  assign w_pend_clr = (r_state == EXC_RD) && w_last;
  assign w_counting = (r_state == FETCH) || (r_state == LOAD) || (r_state == EXC_RD);

  // The vector comes from the pending register, which is frozen until the last EXC_RD cycle,
  // so iord cannot change while the vector read is in flight.
  always_comb begin
    w_vec = 3'b000;
    case (r_pend_code)
      2'b01:   w_vec = 3'b010;
      2'b10:   w_vec = 3'b011;
      2'b11:   w_vec = 3'b100;
      default: w_vec = 3'b000;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= 3'd0;
    end else if (w_counting && !w_last) begin
      r_cnt <= r_cnt + 3'd1;
    end else begin
      r_cnt <= 3'd0;
    end
  end

  // First exception wins; a new one may only replace the pending slot in the cycle it is freed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pend_valid <= 1'b0;
      r_pend_code  <= 2'b00;
    end else if (w_exc_in && (!r_pend_valid || w_pend_clr)) begin
      r_pend_valid <= 1'b1;
      r_pend_code  <= bus.exc_code;
    end else if (w_pend_clr) begin
      r_pend_valid <= 1'b0;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_iord      = 3'b000;
    w_mem_wr    = 1'b0;
    w_ir_wr     = 1'b0;
    w_mdr_wr    = 1'b0;
    w_epc_wr    = 1'b0;
    w_pc_vec_wr = 1'b0;
    w_busy      = 1'b1;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        w_busy = 1'b0;
        if (r_pend_valid || w_exc_in) begin
          w_next = EXC_EPC;
        end else if (bus.data_req) begin
          w_next = bus.data_we ? STORE : LOAD;
        end else if (bus.fetch_req) begin
          w_next = FETCH;
        end
      end
      FETCH: begin
        if (w_last) begin
          w_ir_wr = 1'b1;
          w_done  = 1'b1;
          w_next  = IDLE;
        end
      end
      LOAD: begin
        w_iord = 3'b001;
        if (w_last) begin
          w_mdr_wr = 1'b1;
          w_done   = 1'b1;
          w_next   = IDLE;
        end
      end
      STORE: begin
        w_iord   = 3'b001;
        w_mem_wr = 1'b1;
        w_done   = 1'b1;
        w_next   = IDLE;
      end
      EXC_EPC: begin
        w_iord   = w_vec;
        w_epc_wr = 1'b1;
        w_next   = EXC_RD;
      end
      EXC_RD: begin
        w_iord = w_vec;
        if (w_last) begin
          w_pc_vec_wr = 1'b1;
          w_done      = 1'b1;
          w_next      = IDLE;
        end
      end
      default: begin
        w_next = IDLE;
        w_busy = 1'b0;
      end
    endcase
  end

  assign bus.iord      = w_iord;
  assign bus.mem_wr    = w_mem_wr;
  assign bus.ir_wr     = w_ir_wr;
  assign bus.mdr_wr    = w_mdr_wr;
  assign bus.epc_wr    = w_epc_wr;
  assign bus.pc_vec_wr = w_pc_vec_wr;
  assign bus.busy      = w_busy;
  assign bus.done      = w_done;

endmodule

// File: doc/mem_access_seq.md
Name: mem_access_seq

Overview:
- Multicycle memory-access sequencer for the CPU datapath.
- Owns the 3-bit address-source select (iord) of the memory address mux.
- Arbitrates instruction fetch, data load/store and exception-vector fetch, and issues the matching write strobes: IR, MDR, EPC, memory write and PC-from-vector.
- Sits between the main control FSM and the memory / address-mux path.

Parameters:
- MEM_LAT, 2, read wait cycles before memory data is valid (legal range 1..7).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- fetch_req  in  1  level; request an instruction fetch at PC
- data_req  in  1  level; request a data access at ALUOut
- data_we  in  1  with data_req: 1 = store, 0 = load
- exc_req  in  1  one-cycle pulse; exception raised
- exc_code  in  2  01 invalid opcode, 10 overflow, 11 divide-by-zero, 00 ignored
- iord  out  3  address-mux select: 000 PC, 001 ALUOut, 010 vector A (opcode), 011 vector B (overflow), 100 vector C (div0)
- mem_wr  out  1  memory write strobe
- ir_wr  out  1  instruction-register load strobe
- mdr_wr  out  1  memory-data-register load strobe
- epc_wr  out  1  EPC load strobe (EPC takes PC-4; done by datapath)
- pc_vec_wr  out  1  PC load from memory byte at vector address
- busy  out  1  high in every non-IDLE state
- done  out  1  one-cycle pulse in the final cycle of any access

Behaviour:
- Reset (async, any time including mid-access): state=IDLE, iord=000, all strobes=0, busy=0, done=0, exception-pending register cleared. Outputs are registered or decoded from state only; no input-to-output combinational paths.
- States: IDLE, FETCH, LOAD, STORE, EXC_EPC, EXC_RD. A 3-bit wait counter runs in FETCH, LOAD and EXC_RD.
- IDLE: iord=000, busy=0. Requests are sampled each cycle. Priority: pending or incoming exception > data_req > fetch_req. The winner is entered at the next edge; the counter is loaded with 0.
- FETCH: iord=000 for MEM_LAT+1 cycles. In the final cycle (counter==MEM_LAT), ir_wr=1 and done=1. Next state is IDLE.
- LOAD: iord=001 for MEM_LAT+1 cycles; mdr_wr=1 and done=1 in the final cycle. Next state is IDLE.
- STORE: a single cycle with iord=001, mem_wr=1, done=1. Next state is IDLE.
- EXC_EPC: one cycle with epc_wr=1 and iord=vector code. Next state is EXC_RD.
- EXC_RD: iord=vector code held for MEM_LAT+1 cycles; pc_vec_wr=1 and done=1 in the final cycle. Next state is IDLE. The pending register is cleared in this final cycle.
- Vector code mapping: exc_code 01->010, 10->011, 11->100.
- Exception capture: an exc_req with exc_code!=00 is latched into the pending register in any state.
  - If a pending exception already exists, the new one is dropped (first wins).
  - The current access always completes; the exception is served on return to IDLE.
  - exc_req arriving in the same cycle the pending register is cleared is latched as a new pending exception.
  - exc_code=00 with exc_req=1 is ignored.
- Requests are levels. The controller does not queue fetch/data requests; the requester holds them until done. A request still high in the cycle after done is re-accepted, giving minimum one IDLE cycle between accesses.
- data_we is sampled only at acceptance; changes mid-access are ignored.
- iord must be stable (no glitching between codes) for the whole duration of a read state.
- Simultaneous fetch_req and data_req in IDLE: data first; fetch is served after the following IDLE cycle if still held.

Test Plan:
- MEM_LAT=2, fetch_req=1 at IDLE → 3 cycles iord=000, ir_wr=1 and done=1 in the 3rd cycle only, then IDLE with busy=0.
- data_req=1, data_we=0 → 3 cycles iord=001, mdr_wr pulse in the 3rd cycle; then data_we=1 → one cycle iord=001, mem_wr=1, done=1.
- exc_req pulse with exc_code=10 in IDLE → EXC_EPC (epc_wr=1, iord=011), then 3 cycles iord=011 with pc_vec_wr=1 on the last.
- exc_code=11 pulse during the 2nd cycle of FETCH, with fetch_req and data_req both held → fetch completes (ir_wr), IDLE, then exception served with iord=100 before the data access; a second exc_req (code 01) during the pending window is dropped.
- fetch_req and data_req asserted together → LOAD/STORE first, one IDLE cycle, then FETCH.
- Assert reset in the 2nd cycle of EXC_RD → same cycle: iord=000, all strobes 0, busy=0; after release with no requests, stays IDLE (pending cleared, no vector fetch).
